req_arbiter_ctrl: RTL
=====================

Name: req_arbiter_ctrl

Overview:
- Four-requester arbiter that shares one downstream resource, e.g. a 2-bit-coded output bus.
- Takes the raw request lines, picks an owner by fixed priority (req[0] highest), then holds the grant until the owner releases or a hold timeout expires.
- Grant outputs are registered, with a mandatory one-cycle turnaround between owners.
- Sits between the request sources and the shared datapath; drives its select/encode.

Parameters:
- NREQ, 4, number of requesters; fixed at 4 in this revision so grant_id fits 2 bits.
- MAX_HOLD, 16, maximum consecutive GRANT cycles per owner before forced release; legal range 2..255.
- HOLD_W, 8, width of the hold counter; must satisfy 2**HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  request lines; level-sensitive; req[0] highest priority
- grant  output  4  one-hot grant; all zero when no owner
- grant_id  output  2  binary index of current owner; 0 when no owner
- grant_valid  output  1  high while an owner holds the resource
- timeout  output  1  one-cycle pulse when an owner is released by MAX_HOLD

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: grant=0, grant_id=0, grant_valid=0, timeout=0, state=IDLE, hold counter=0, masked id=none.
- States: IDLE, GRANT, TURN.
- IDLE:
  - If req!=0, pick the winner by priority, excluding the masked id if any other request is pending.
  - Register grant/grant_id/grant_valid=1 on the next edge; go to GRANT.
  - Latency is 1 cycle from req sampled to grant visible.
  - If req==0, stay in IDLE with outputs zero.
- GRANT:
  - Hold counter increments each cycle, starting at 1 on the first GRANT cycle.
  - If req[grant_id] is low, go to TURN. The owner loses grant on the edge after it drops req, and no timeout is raised.
  - Else if the counter reaches MAX_HOLD, go to TURN, pulse timeout for exactly 1 cycle (the first TURN cycle), and set the masked id to the owner.
  - Higher-priority requests arriving during GRANT do not preempt.
- TURN:
  - All grant outputs are 0 for exactly 1 cycle; the counter clears; go to IDLE.
  - Re-arbitration therefore happens in IDLE, so minimum owner-to-owner gap is 2 cycles of grant_valid=0.
- Masked id:
  - Cleared when a different requester is granted, or when IDLE arbitration finds only the masked requester pending.
  - In the latter case the masked requester is granted again; no starvation of a lone requester.
- Simultaneous requests: the lowest index wins, subject to the mask.
- The owner dropping req in the same cycle the counter hits MAX_HOLD is treated as a release: no timeout, no mask.
- Reset asserted mid-GRANT: outputs clear immediately (asynchronous); after deassert, start in IDLE.
- Invariant: grant is one-hot or zero; grant_valid == |grant.

Optional Feature:
- Macro: ROUND_ROBIN_EN.
- Defined: after each grant, the priority base rotates to (grant_id+1) mod 4. Arbitration searches from the base upward with wrap. The mask logic is still present but is naturally redundant.
- Undefined: fixed priority req[0]>req[1]>req[2]>req[3], as described above.

Decomposition:
- Package arb_pkg holds:
  - state enum {IDLE, GRANT, TURN}
  - constants NREQ=4 and ID_W=2
  - a function one-hot-from-id
- Sub-module prio_pick holds the combinational pick:
  - inputs: req[3:0], base[1:0], mask_en, mask_id[1:0]
  - outputs: found, id[1:0]
  - With base tied to 0 it is the fixed-priority encoder; the controller instantiates it once.

Test Plan:
- Reset then req=4'b0000 for 5 cycles -> grant=0, grant_valid=0, timeout=0 throughout.
- req=4'b1010 held -> after 1 cycle grant=4'b0010, grant_id=1. Drop req[1] -> grant=0 next edge, 1 TURN cycle, then grant=4'b1000, grant_id=3.
- req[2] held continuously, MAX_HOLD=16 -> grant_valid high for exactly 16 cycles, timeout pulse 1 cycle, gap, then req[2] regranted because it is the lone requester.
- req=4'b0101 held, owner 0 times out -> next grant goes to id 2 (mask), and after id 2 releases, id 0 is granted.
- req[3] granted, then req[0] asserts mid-hold -> no preemption; grant_id stays 3 until req[3] drops.
- Assert rst_n=0 mid-GRANT (between clock edges) -> grant/grant_valid clear immediately; after release with req=4'b0001, grant=4'b0001 after 1 cycle.
- With ROUND_ROBIN_EN, req=4'b1111 held and each owner dropping after 2 cycles -> grant order 0,1,2,3,0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types, constants and helpers for the four-requester arbiter.
// Optional ROUND_ROBIN_EN build macro is consumed by req_arbiter_ctrl.
package arb_pkg;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  function automatic logic [NREQ-1:0] onehot_from_id(input logic [ID_W-1:0] id);
    logic [NREQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational priority pick: searches upward from base with wrap, skipping
// mask_id whenever some other request is pending.
module prio_pick
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] base,
  input  logic            mask_en,
  input  logic [ID_W-1:0] mask_id,
  output logic            found,
  output logic [ID_W-1:0] id
);

  logic [NREQ-1:0] others;
  logic [NREQ-1:0] cand;
  logic [ID_W-1:0] idx;

  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    others = req & ~onehot_from_id(mask_id);
    cand   = (mask_en && (others != '0)) ? others : req;
    found  = |cand;
    id     = '0;
    idx    = '0;
    // Walk from the farthest position back to base; the last hit wins.
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = base + ID_W'(i);
      if (cand[idx]) id = idx;
    end
  end

endmodule

// File: rtl/req_arbiter_ctrl.sv
// Four-requester arbiter with hold timeout and one-cycle turnaround.
// Define ROUND_ROBIN_EN to rotate the priority base after every grant.
module req_arbiter_ctrl
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_id,
  output logic            grant_valid,
  output logic            timeout
);

  state_t            state, state_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic              mask_en, mask_en_next;
  logic [ID_W-1:0]   mask_id, mask_id_next;
  logic [ID_W-1:0]   base;
  logic [NREQ-1:0]   grant_next;
  logic [ID_W-1:0]   grant_id_next;
  logic              grant_valid_next;
  logic              timeout_next;
  logic              pick_found;
  logic [ID_W-1:0]   pick_id;
  logic              owner_req;
  logic              hold_done;

  prio_pick u_pick (
    .req     (req),
    .base    (base),
    .mask_en (mask_en),
    .mask_id (mask_id),
    .found   (pick_found),
    .id      (pick_id)
  );

  assign owner_req = req[grant_id];
  assign hold_done = (hold_cnt == HOLD_W'(MAX_HOLD));

`ifdef ROUND_ROBIN_EN
  logic [ID_W-1:0] base_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) base <= '0;
    else        base <= base_next;
  end

  always_comb begin
    base_next = base;
    if (state == IDLE && pick_found) base_next = pick_id + ID_W'(1);
  end
`else
  assign base = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (pick_found) state_next = GRANT;
      GRANT:   if (!owner_req || hold_done) state_next = TURN;
      TURN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs and bookkeeping.
  always_comb begin
    grant_next       = '0;
    grant_id_next    = '0;
    grant_valid_next = 1'b0;
    timeout_next     = 1'b0;
    hold_next        = hold_cnt;
    mask_en_next     = mask_en;
    mask_id_next     = mask_id;
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          grant_next       = onehot_from_id(pick_id);
          grant_id_next    = pick_id;
          grant_valid_next = 1'b1;
          hold_next        = HOLD_W'(1);
          // Either a different requester won or the masked one was alone.
          mask_en_next     = 1'b0;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          hold_next = hold_cnt;
        end else if (hold_done) begin
          timeout_next = 1'b1;
          mask_en_next = 1'b1;
          mask_id_next = grant_id;
        end else begin
          grant_next       = grant;
          grant_id_next    = grant_id;
          grant_valid_next = 1'b1;
          hold_next        = hold_cnt + HOLD_W'(1);
        end
      end
      TURN: begin
        hold_next = '0;
      end
      default: begin
        hold_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      hold_cnt    <= '0;
      mask_en     <= 1'b0;
      mask_id     <= '0;
    end else begin
      grant       <= grant_next;
      grant_id    <= grant_id_next;
      grant_valid <= grant_valid_next;
      timeout     <= timeout_next;
      hold_cnt    <= hold_next;
      mask_en     <= mask_en_next;
      mask_id     <= mask_id_next;
    end
  end

endmodule
